// File: rtl/stage_writeback_pkg.sv
// Shared core definitions for the writeback stage: rd source select,
// load funct3 codes and the captured M->W pipeline register layout.
package stage_writeback_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_CSR  = 2'b11
  } reg_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        csr_write;
    reg_src_e    reg_src;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic [11:0] csr_addr;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [31:0] csr_old;
  } wb_reg_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/stage_writeback_load_extend.sv
// Selects the addressed byte/halfword lane of a loaded word and
// sign- or zero-extends it according to the load funct3 code.
module load_extend
  import stage_writeback_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = '0;
    case (addr)
      2'b00: byte_lane = word[7:0];
      2'b01: byte_lane = word[15:8];
      2'b10: byte_lane = word[23:16];
      2'b11: byte_lane = word[31:24];
      default: byte_lane = '0;
    endcase
  end

  // Halfword lane only looks at addr[1]; misaligned bit 0 is ignored.
  assign half_lane = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    value = word;
    case (funct3)
      F3_LB:   value = ext8(byte_lane, 1'b1);
      F3_LH:   value = ext16(half_lane, 1'b1);
      F3_LW:   value = word;
      F3_LBU:  value = ext8(byte_lane, 1'b0);
      F3_LHU:  value = ext16(half_lane, 1'b0);
      default: value = word;
    endcase
  end

endmodule

// File: rtl/stage_writeback.sv
// Writeback stage: M->W pipeline register, rd result select, register/CSR
// write ports and the retired-instruction counter.
module stage_writeback
  import stage_writeback_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              validM,
  input  logic              regWriteM,
  input  logic              csrWriteM,
  input  logic [1:0]        regSrcM,
  input  logic [2:0]        funct3M,
  input  logic [4:0]        rdAddrM,
  input  logic [11:0]       csrAddrM,
  input  logic [31:0]       aluResultM,
  input  logic [31:0]       readDataM,
  input  logic [31:0]       pcPlus4M,
  input  logic [31:0]       csrOldM,
  output logic [4:0]        rdAddrW,
  output logic              regWriteW,
  output logic [31:0]       rdW,
  output logic              csrWriteW,
  output logic [11:0]       csrAddrW,
  output logic [31:0]       csrResultW,
  output logic              validW,
  output logic [CNT_W-1:0]  instretW
);

  wb_reg_t          w_q;
  wb_reg_t          m_in;
  logic [CNT_W-1:0] instret_q;
  logic [31:0]      load_value;

  always_comb begin
    m_in            = '0;
    m_in.valid      = validM;
    m_in.reg_write  = regWriteM;
    m_in.csr_write  = csrWriteM;
    m_in.reg_src    = reg_src_e'(regSrcM);
    m_in.funct3     = funct3M;
    m_in.rd_addr    = rdAddrM;
    m_in.csr_addr   = csrAddrM;
    m_in.alu_result = aluResultM;
    m_in.read_data  = readDataM;
    m_in.pc_plus4   = pcPlus4M;
    m_in.csr_old    = csrOldM;
  end

  // Priority: rst > flush > stall > capture. The counter only advances on a
  // real capture of a valid instruction and wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q       <= '0;
      instret_q <= '0;
    end else if (flush) begin
      w_q <= '0;
    end else if (!stall) begin
      w_q <= m_in;
      if (validM) instret_q <= instret_q + CNT_W'(1);
    end
  end

  load_extend u_load_extend (
    .funct3 (w_q.funct3),
    .addr   (w_q.alu_result[1:0]),
    .word   (w_q.read_data),
    .value  (load_value)
  );

  always_comb begin
    rdW = w_q.alu_result;
    case (w_q.reg_src)
      SRC_ALU:  rdW = w_q.alu_result;
      SRC_LOAD: rdW = load_value;
      SRC_PC4:  rdW = w_q.pc_plus4;
      SRC_CSR:  rdW = w_q.csr_old;
      default:  rdW = w_q.alu_result;
    endcase
  end

  assign rdAddrW    = w_q.rd_addr;
  assign validW     = w_q.valid;
  assign regWriteW  = w_q.reg_write & w_q.valid & (w_q.rd_addr != 5'd0);
  assign csrWriteW  = w_q.csr_write & w_q.valid;
  assign csrAddrW   = w_q.csr_addr;
  assign csrResultW = w_q.alu_result;
  assign instretW   = instret_q;

endmodule

// File: tb/tb_stage_writeback.sv
// Directed-vector bench for stage_writeback, built with an 8-bit counter so
// the wraparound case is reachable.
module tb_stage_writeback;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst, stall, flush, validM, regWriteM, csrWriteM;
  logic [1:0]    regSrcM;
  logic [2:0]    funct3M;
  logic [4:0]    rdAddrM;
  logic [11:0]   csrAddrM;
  logic [31:0]   aluResultM, readDataM, pcPlus4M, csrOldM;
  logic [4:0]    rdAddrW;
  logic          regWriteW, csrWriteW, validW;
  logic [31:0]   rdW, csrResultW;
  logic [11:0]   csrAddrW;
  logic [CW-1:0] instretW;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  stage_writeback #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .validM(validM), .regWriteM(regWriteM), .csrWriteM(csrWriteM),
    .regSrcM(regSrcM), .funct3M(funct3M), .rdAddrM(rdAddrM),
    .csrAddrM(csrAddrM), .aluResultM(aluResultM), .readDataM(readDataM),
    .pcPlus4M(pcPlus4M), .csrOldM(csrOldM),
    .rdAddrW(rdAddrW), .regWriteW(regWriteW), .rdW(rdW),
    .csrWriteW(csrWriteW), .csrAddrW(csrAddrW), .csrResultW(csrResultW),
    .validW(validW), .instretW(instretW)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic v, input logic rw, input logic cw,
                         input logic [1:0] src, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [11:0] csr,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [31:0] old);
    validM = v; regWriteM = rw; csrWriteM = cw; regSrcM = src; funct3M = f3;
    rdAddrM = rd; csrAddrM = csr; aluResultM = alu; readDataM = rdata;
    pcPlus4M = pc4; csrOldM = old;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_validW"},     64'(validW),     64'h0);
    check({tag, "_regWriteW"},  64'(regWriteW),  64'h0);
    check({tag, "_csrWriteW"},  64'(csrWriteW),  64'h0);
    check({tag, "_rdW"},        64'(rdW),        64'h0);
    check({tag, "_rdAddrW"},    64'(rdAddrW),    64'h0);
    check({tag, "_csrAddrW"},   64'(csrAddrW),   64'h0);
    check({tag, "_csrResultW"}, 64'(csrResultW), 64'h0);
    check({tag, "_instretW"},   64'(instretW),   64'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_m(1'b1, 1'b1, 1'b1, 2'b01, 3'b000, 5'd9, 12'h123,
            32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    tick(); tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    exp_cnt = '0;

    // LB: byte lane 3 of 0x80FFFF7F is 0x80
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 3'b000, 5'd5, 12'h0,
            32'h0000_1003, 32'h80FF_FF7F, 32'h0, 32'h0);
    tick(); exp_cnt++;
    check("lb_rdW", 64'(rdW), 64'hFFFF_FF80);
    check("lb_rdAddrW", 64'(rdAddrW), 64'd5);
    check("lb_regWriteW", 64'(regWriteW), 64'h1);
    check("lb_validW", 64'(validW), 64'h1);
    check("lb_instret", 64'(instretW), 64'(exp_cnt));

    funct3M = 3'b100;
    tick(); exp_cnt++;
    check("lbu_rdW", 64'(rdW), 64'h0000_0080);
    check("lbu_instret", 64'(instretW), 64'(exp_cnt));

    aluResultM = 32'h0000_1001; funct3M = 3'b000;
    tick(); exp_cnt++;
    check("lb_lane1_rdW", 64'(rdW), 64'hFFFF_FFFF);

    // LH / LHU upper half 0x8001
    aluResultM = 32'h0000_2002; readDataM = 32'h8001_1234; funct3M = 3'b001;
    tick(); exp_cnt++;
    check("lh_rdW", 64'(rdW), 64'hFFFF_8001);
    funct3M = 3'b101;
    tick(); exp_cnt++;
    check("lhu_rdW", 64'(rdW), 64'h0000_8001);
    aluResultM = 32'h0000_2003; funct3M = 3'b001;
    tick(); exp_cnt++;
    check("lh_addr0_ignored_rdW", 64'(rdW), 64'hFFFF_8001);
    aluResultM = 32'h0000_2000;
    tick(); exp_cnt++;
    check("lh_lower_rdW", 64'(rdW), 64'h0000_1234);
    funct3M = 3'b010; aluResultM = 32'h0000_2003;
    tick(); exp_cnt++;
    check("lw_rdW", 64'(rdW), 64'h8001_1234);
    funct3M = 3'b111;
    tick(); exp_cnt++;
    check("f3_111_rdW", 64'(rdW), 64'h8001_1234);

    // ALU source
    drive_m(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd31, 12'h0,
            32'hCAFE_0001, 32'h0, 32'h0, 32'h0);
    tick(); exp_cnt++;
    check("alu_rdW", 64'(rdW), 64'hCAFE_0001);
    check("alu_rdAddrW", 64'(rdAddrW), 64'd31);

    // x0 is never written
    drive_m(1'b1, 1'b1, 1'b0, 2'b10, 3'b000, 5'd0, 12'h0,
            32'h0, 32'h0, 32'h0000_0104, 32'h0);
    tick(); exp_cnt++;
    check("x0_regWriteW", 64'(regWriteW), 64'h0);
    check("x0_rdW", 64'(rdW), 64'h104);
    check("x0_instret", 64'(instretW), 64'(exp_cnt));

    // Bubble from M: nothing written, counter holds
    drive_m(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 12'h301,
            32'h55, 32'h0, 32'h0, 32'h0);
    tick();
    check("invalid_regWriteW", 64'(regWriteW), 64'h0);
    check("invalid_csrWriteW", 64'(csrWriteW), 64'h0);
    check("invalid_validW", 64'(validW), 64'h0);
    check("invalid_instret", 64'(instretW), 64'(exp_cnt));

    // CSR write with old value to rd
    drive_m(1'b1, 1'b1, 1'b1, 2'b11, 3'b000, 5'd7, 12'h300,
            32'h0000_0008, 32'h0, 32'h0, 32'h0000_0005);
    tick(); exp_cnt++;
    check("csr_csrWriteW", 64'(csrWriteW), 64'h1);
    check("csr_csrAddrW", 64'(csrAddrW), 64'h300);
    check("csr_csrResultW", 64'(csrResultW), 64'h8);
    check("csr_rdW", 64'(rdW), 64'h5);
    check("csr_regWriteW", 64'(regWriteW), 64'h1);
    check("csr_instret", 64'(instretW), 64'(exp_cnt));

    // Stall holds W and the counter
    stall = 1'b1;
    drive_m(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd12, 12'h0,
            32'hAAAA_AAAA, 32'h0, 32'h0, 32'h0);
    tick();
    check("stall_rdW", 64'(rdW), 64'h5);
    check("stall_rdAddrW", 64'(rdAddrW), 64'd7);
    check("stall_csrWriteW", 64'(csrWriteW), 64'h1);
    check("stall_instret", 64'(instretW), 64'(exp_cnt));

    // Release stall: held M instruction is captured
    stall = 1'b0;
    tick(); exp_cnt++;
    check("unstall_rdW", 64'(rdW), 64'hAAAA_AAAA);
    check("unstall_instret", 64'(instretW), 64'(exp_cnt));

    // Flush beats stall
    stall = 1'b1; flush = 1'b1;
    tick();
    check("flush_validW", 64'(validW), 64'h0);
    check("flush_regWriteW", 64'(regWriteW), 64'h0);
    check("flush_rdW", 64'(rdW), 64'h0);
    check("flush_rdAddrW", 64'(rdAddrW), 64'h0);
    check("flush_instret", 64'(instretW), 64'(exp_cnt));
    stall = 1'b0; flush = 1'b0;

    // In-flight write discarded by mid-operation reset
    drive_m(1'b1, 1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 12'h305,
            32'h1234_5678, 32'h0, 32'h0, 32'h0);
    tick(); exp_cnt++;
    check("pre_rst_regWriteW", 64'(regWriteW), 64'h1);
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    check_zero_outputs("midrst");
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    exp_cnt = '0;

    // Counter wrap: 255 captures then one more
    drive_m(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 5'd1, 12'h0,
            32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 255; i++) tick();
    check("preload_instret", 64'(instretW), 64'hFF);
    tick();
    check("wrap_instret", 64'(instretW), 64'h0);
    tick();
    check("after_wrap_instret", 64'(instretW), 64'h1);
    rst = 1'b1;
    tick();
    check("final_rst_instret", 64'(instretW), 64'h0);
    check("final_rst_validW", 64'(validW), 64'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
